// File: rtl/usb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : usb_pkg
// Description : Shared USB full-speed types: RX FSM states, PID codes and
//               packet type codes used by both the RX and TX control paths.
// Revision    : 1.0 - initial release
// ============================================================================
package usb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PID      = 3'd1,
        ST_TOK1     = 3'd2,
        ST_TOK2     = 3'd3,
        ST_WAIT_EOP = 3'd4,
        ST_DATA     = 3'd5,
        ST_DONE     = 3'd6,
        ST_ERR      = 3'd7
    } rx_state_t;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;

    typedef enum logic [2:0] {
        PKT_NONE = 3'd0,
        PKT_OUT  = 3'd1,
        PKT_IN   = 3'd2,
        PKT_DATA = 3'd3,
        PKT_ACK  = 3'd4,
        PKT_NAK  = 3'd5
    } usb_packet_t;

    // Upper nibble of a PID byte must be the ones-complement of the lower.
    function automatic logic pid_check_ok(input logic [7:0] b);
        return (b[7:4] == ~b[3:0]);
    endfunction

    function automatic usb_packet_t pid_decode(input logic [3:0] pid);
        case (pid)
            PID_OUT:   return PKT_OUT;
            PID_IN:    return PKT_IN;
            PID_DATA0: return PKT_DATA;
            PID_DATA1: return PKT_DATA;
            PID_ACK:   return PKT_ACK;
            PID_NAK:   return PKT_NAK;
            default:   return PKT_NONE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/usb_rx_hold2.sv
`default_nettype none
// ============================================================================
// Module      : usb_rx_hold2
// Description : Two-byte delay pipeline that withholds the trailing CRC16 of a
//               DATA packet; emits the oldest byte once a third byte arrives.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_rx_hold2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clr,
    input  logic       i_push,
    input  logic       i_block,
    input  logic [7:0] i_byte,
    output logic       o_full,
    output logic       o_store,
    output logic [7:0] o_data
);

    logic [7:0] r_h0;
    logic [7:0] r_h1;
    logic [1:0] r_fill;
    logic       r_store;
    logic [7:0] r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_h0    <= 8'h00;
            r_h1    <= 8'h00;
            r_fill  <= 2'd0;
            r_store <= 1'b0;
            r_data  <= 8'h00;
        end else begin
            r_store <= 1'b0;
            if (i_clr) begin
                r_h0   <= 8'h00;
                r_h1   <= 8'h00;
                r_fill <= 2'd0;
            end else if (i_push) begin
                if (r_fill == 2'd2) begin
                    // A blocked push leaves the pipeline untouched; the
                    // controller is abandoning the packet anyway.
                    if (!i_block) begin
                        r_store <= 1'b1;
                        r_data  <= r_h0;
                        r_h0    <= r_h1;
                        r_h1    <= i_byte;
                    end
                end else begin
                    if (r_fill == 2'd0) begin
                        r_h0 <= i_byte;
                    end else begin
                        r_h1 <= i_byte;
                    end
                    r_fill <= r_fill + 2'd1;
                end
            end
        end
    end

    assign o_full  = (r_fill == 2'd2);
    assign o_store = r_store;
    assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/usb_rx_control.sv
`default_nettype none
// ============================================================================
// Module      : usb_rx_control
// Description : USB full-speed receive packet controller: SYNC/PID checking,
//               token field capture and CRC-stripped DATA payload streaming.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_rx_control
    import usb_pkg::*;
#(
    parameter int         MAX_PAYLOAD = 64,
    parameter logic [7:0] SYNC_BYTE   = 8'h80
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_byte,
    input  logic       rx_byte_valid,
    input  logic       eop,
    output logic       rx_transfer_active,
    output logic [2:0] rx_packet,
    output logic [6:0] rx_address,
    output logic [3:0] rx_endpoint,
    output logic       store_rx_packet_data,
    output logic [7:0] rx_packet_data,
    output logic       rx_data_ready,
    output logic       rx_error
);

    localparam logic [6:0] c_max_payload = 7'(MAX_PAYLOAD);
    localparam logic [6:0] c_cnt_sat     = 7'h7F;

    rx_state_t   r_state;
    rx_state_t   w_next_state;
    usb_packet_t r_packet;
    logic [6:0]  r_address;
    logic [3:0]  r_endpoint;
    logic        r_error;
    logic        r_eop_seen;
    logic [6:0]  r_payload_cnt;

    logic        w_sync;
    logic        w_byte;
    logic        w_push;
    logic        w_full;
    logic        w_block;
    logic        w_err_eop;
    logic        w_pid_ok;
    usb_packet_t w_pid_pkt;

    assign w_sync    = (r_state == ST_IDLE) && rx_byte_valid && (rx_byte == SYNC_BYTE);
    assign w_byte    = rx_byte_valid && !eop;
    assign w_push    = (r_state == ST_DATA) && w_byte;
    assign w_block   = w_push && w_full && (r_payload_cnt >= c_max_payload);
    assign w_pid_ok  = pid_check_ok(rx_byte);
    assign w_pid_pkt = pid_decode(rx_byte[3:0]);

    always_comb begin
        w_next_state = r_state;
        w_err_eop    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_sync) w_next_state = ST_PID;
            end
            ST_PID: begin
                if (eop) begin
                    w_next_state = ST_ERR;
                    w_err_eop    = 1'b1;
                end else if (rx_byte_valid) begin
                    if (!w_pid_ok) begin
                        w_next_state = ST_ERR;
                    end else begin
                        case (w_pid_pkt)
                            PKT_OUT, PKT_IN:   w_next_state = ST_TOK1;
                            PKT_DATA:          w_next_state = ST_DATA;
                            PKT_ACK, PKT_NAK:  w_next_state = ST_WAIT_EOP;
                            default:           w_next_state = ST_ERR;
                        endcase
                    end
                end
            end
            ST_TOK1, ST_TOK2: begin
                if (eop) begin
                    w_next_state = ST_ERR;
                    w_err_eop    = 1'b1;
                end else if (rx_byte_valid) begin
                    w_next_state = (r_state == ST_TOK1) ? ST_TOK2 : ST_WAIT_EOP;
                end
            end
            ST_WAIT_EOP: begin
                if (eop) begin
                    w_next_state = rx_byte_valid ? ST_ERR : ST_DONE;
                    w_err_eop    = rx_byte_valid;
                end else if (rx_byte_valid) begin
                    w_next_state = ST_ERR;
                end
            end
            ST_DATA: begin
                // Fewer than two held bytes at eop means no room for CRC16.
                if (eop) begin
                    if (rx_byte_valid || !w_full) begin
                        w_next_state = ST_ERR;
                        w_err_eop    = 1'b1;
                    end else begin
                        w_next_state = ST_DONE;
                    end
                end else if (w_block) begin
                    w_next_state = ST_ERR;
                end
            end
            ST_DONE: w_next_state = ST_IDLE;
            ST_ERR: begin
                if (eop || r_eop_seen) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_packet      <= PKT_NONE;
            r_address     <= 7'h00;
            r_endpoint    <= 4'h0;
            r_error       <= 1'b0;
            r_eop_seen    <= 1'b0;
            r_payload_cnt <= 7'h00;
        end else begin
            r_state    <= w_next_state;
            r_eop_seen <= w_err_eop;
            if (w_sync) begin
                r_error       <= 1'b0;
                r_packet      <= PKT_NONE;
                r_payload_cnt <= 7'h00;
            end else if ((w_next_state == ST_ERR) && (r_state != ST_ERR)) begin
                r_error <= 1'b1;
            end
            if ((r_state == ST_PID) && w_byte) begin
                r_packet <= w_pid_ok ? w_pid_pkt : PKT_NONE;
            end
            if ((r_state == ST_TOK1) && w_byte) begin
                r_address     <= rx_byte[6:0];
                r_endpoint[0] <= rx_byte[7];
            end
            if ((r_state == ST_TOK2) && w_byte) begin
                r_endpoint[3:1] <= rx_byte[2:0];
            end
            if (w_push && w_full && !w_block && (r_payload_cnt != c_cnt_sat)) begin
                r_payload_cnt <= r_payload_cnt + 7'd1;
            end
        end
    end

    usb_rx_hold2 u_hold2 (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_sync),
        .i_push  (w_push),
        .i_block (w_block),
        .i_byte  (rx_byte),
        .o_full  (w_full),
        .o_store (store_rx_packet_data),
        .o_data  (rx_packet_data)
    );

    assign rx_transfer_active = (r_state != ST_IDLE);
    assign rx_data_ready      = (r_state == ST_DONE);
    assign rx_packet          = r_packet;
    assign rx_address         = r_address;
    assign rx_endpoint        = r_endpoint;
    assign rx_error           = r_error;

endmodule
`default_nettype wire

// File: tb/tb_usb_rx_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_usb_rx_control
// Description : Self-checking bench for usb_rx_control: packet vector table
//               plus hand sequences, with a payload store scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_rx_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_byte;
    logic       rx_byte_valid;
    logic       eop;
    logic       rx_transfer_active;
    logic [2:0] rx_packet;
    logic [6:0] rx_address;
    logic [3:0] rx_endpoint;
    logic       store_rx_packet_data;
    logic [7:0] rx_packet_data;
    logic       rx_data_ready;
    logic       rx_error;

    always #5 clk = ~clk;

    usb_rx_control #(
        .MAX_PAYLOAD (64),
        .SYNC_BYTE   (8'h80)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .rx_byte              (rx_byte),
        .rx_byte_valid        (rx_byte_valid),
        .eop                  (eop),
        .rx_transfer_active   (rx_transfer_active),
        .rx_packet            (rx_packet),
        .rx_address           (rx_address),
        .rx_endpoint          (rx_endpoint),
        .store_rx_packet_data (store_rx_packet_data),
        .rx_packet_data       (rx_packet_data),
        .rx_data_ready        (rx_data_ready),
        .rx_error             (rx_error)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] obs_mem [0:255];
    int         obs_wr    = 0;
    int         obs_rd    = 0;
    int         ready_cnt = 0;

    always @(negedge clk) begin
        if (store_rx_packet_data) begin
            obs_mem[obs_wr[7:0]] = rx_packet_data;
            obs_wr = obs_wr + 1;
        end
        if (rx_data_ready) ready_cnt = ready_cnt + 1;
    end

    typedef struct {
        int          n;
        logic [63:0] b;
        logic [2:0]  pkt;
        logic [6:0]  addr;
        logic [3:0]  endp;
        logic        err;
        int          ready;
        int          nstore;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic setv(input int i, input int n, input logic [63:0] b, input logic [2:0] pkt,
                        input logic [6:0] addr, input logic [3:0] endp, input logic err,
                        input int ready, input int nstore);
        vecs[i].n = n; vecs[i].b = b; vecs[i].pkt = pkt; vecs[i].addr = addr;
        vecs[i].endp = endp; vecs[i].err = err; vecs[i].ready = ready; vecs[i].nstore = nstore;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte = b;
        rx_byte_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_byte_valid = 1'b0;
        rx_byte = 8'h00;
    endtask

    task automatic send_eop();
        eop = 1'b1;
        @(posedge clk);
        #1;
        eop = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Count first, then pair observed stores with expected ones in order.
    task automatic drain(input string name);
        int avail;
        avail = obs_wr - obs_rd;
        chk({name, "_store_count"}, 32'(avail), 32'(exp_q.size()));
        while (exp_q.size() > 0) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (obs_rd < obs_wr) begin
                chk({name, "_store_data"}, 32'(obs_mem[obs_rd[7:0]]), 32'(e));
                obs_rd++;
            end
        end
        obs_rd = obs_wr;
    endtask

    initial begin
        int r0;
        rst = 1'b1;
        rx_byte = 8'h00;
        rx_byte_valid = 1'b0;
        eop = 1'b0;
        idle(3);
        chk("rst_active", 32'(rx_transfer_active), 32'd0);
        chk("rst_packet", 32'(rx_packet), 32'd0);
        chk("rst_address", 32'(rx_address), 32'd0);
        chk("rst_endpoint", 32'(rx_endpoint), 32'd0);
        chk("rst_store", 32'(store_rx_packet_data), 32'd0);
        chk("rst_data", 32'(rx_packet_data), 32'd0);
        chk("rst_ready", 32'(rx_data_ready), 32'd0);
        chk("rst_error", 32'(rx_error), 32'd0);
        rst = 1'b0;
        idle(2);

        //   idx n  bytes (wire order)        pkt  addr   endp err rdy st
        setv(0,  4, 64'h80_69_05_E8,           3'd2, 7'h05, 4'h0, 0, 1, 0); // IN token
        setv(1,  4, 64'h80_E1_85_E8,           3'd1, 7'h05, 4'h1, 0, 1, 0); // OUT addr5 ep1
        setv(2,  6, 64'h80_C3_11_22_33_44,     3'd3, 7'h05, 4'h1, 0, 1, 2); // DATA0 2 bytes
        setv(3,  2, 64'h80_C4,                 3'd0, 7'h05, 4'h1, 1, 0, 0); // bad PID check
        setv(4,  3, 64'h80_C3_AA,              3'd3, 7'h05, 4'h1, 1, 0, 0); // runt
        setv(5,  2, 64'h80_5A,                 3'd5, 7'h05, 4'h1, 0, 1, 0); // NAK
        setv(6,  2, 64'h80_D2,                 3'd4, 7'h05, 4'h1, 0, 1, 0); // ACK
        setv(7,  4, 64'h80_4B_12_34,           3'd3, 7'h05, 4'h1, 0, 1, 0); // DATA1 empty
        setv(8,  2, 64'h80_1E,                 3'd0, 7'h05, 4'h1, 1, 0, 0); // unknown PID
        setv(9,  2, 64'h80_E1,                 3'd1, 7'h05, 4'h1, 1, 0, 0); // eop in TOK1
        setv(10, 5, 64'h80_69_0A_03_77,        3'd2, 7'h0A, 4'h6, 1, 0, 0); // byte in WAIT_EOP
        setv(11, 5, 64'h00_FF_80_D2,           3'd4, 7'h0A, 4'h6, 0, 1, 0); // noise then ACK
        vecs[11].n = 4;

        for (int i = 0; i < NV; i++) begin
            r0 = ready_cnt;
            for (int k = 0; k < vecs[i].nstore; k++) begin
                exp_q.push_back(vecs[i].b[8*(vecs[i].n-1-(2+k)) +: 8]);
            end
            for (int k = 0; k < vecs[i].n; k++) begin
                send_byte(vecs[i].b[8*(vecs[i].n-1-k) +: 8]);
            end
            send_eop();
            idle(4);
            chk($sformatf("v%0d_packet", i), 32'(rx_packet), 32'(vecs[i].pkt));
            chk($sformatf("v%0d_address", i), 32'(rx_address), 32'(vecs[i].addr));
            chk($sformatf("v%0d_endpoint", i), 32'(rx_endpoint), 32'(vecs[i].endp));
            chk($sformatf("v%0d_error", i), 32'(rx_error), 32'(vecs[i].err));
            chk($sformatf("v%0d_ready", i), 32'(ready_cnt - r0), 32'(vecs[i].ready));
            chk($sformatf("v%0d_active", i), 32'(rx_transfer_active), 32'd0);
            drain($sformatf("v%0d", i));
        end

        // Oversize DATA: 66 payload + 2 CRC, only 64 bytes may be stored.
        r0 = ready_cnt;
        send_byte(8'h80);
        send_byte(8'hC3);
        for (int k = 0; k < 68; k++) begin
            if (k < 64) exp_q.push_back(8'(k + 1));
            send_byte(8'(k + 1));
        end
        send_eop();
        idle(4);
        chk("big_error", 32'(rx_error), 32'd1);
        chk("big_ready", 32'(ready_cnt - r0), 32'd0);
        chk("big_active", 32'(rx_transfer_active), 32'd0);
        drain("big");

        // Byte and eop together inside DATA: eop wins, packet errors out.
        r0 = ready_cnt;
        exp_q.push_back(8'h11);
        send_byte(8'h80);
        send_byte(8'hC3);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        rx_byte = 8'h44;
        rx_byte_valid = 1'b1;
        eop = 1'b1;
        @(posedge clk);
        #1;
        rx_byte_valid = 1'b0;
        eop = 1'b0;
        idle(4);
        chk("beop_error", 32'(rx_error), 32'd1);
        chk("beop_ready", 32'(ready_cnt - r0), 32'd0);
        chk("beop_active", 32'(rx_transfer_active), 32'd0);
        drain("beop");

        // Reset in the middle of a DATA payload.
        exp_q.push_back(8'hA1);
        exp_q.push_back(8'hA2);
        send_byte(8'h80);
        send_byte(8'hC3);
        send_byte(8'hA1);
        send_byte(8'hA2);
        send_byte(8'hA3);
        send_byte(8'hA4);
        rx_byte = 8'hA5;
        rx_byte_valid = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rx_byte_valid = 1'b0;
        chk("mrst_active", 32'(rx_transfer_active), 32'd0);
        chk("mrst_packet", 32'(rx_packet), 32'd0);
        chk("mrst_address", 32'(rx_address), 32'd0);
        chk("mrst_endpoint", 32'(rx_endpoint), 32'd0);
        chk("mrst_store", 32'(store_rx_packet_data), 32'd0);
        chk("mrst_data", 32'(rx_packet_data), 32'd0);
        chk("mrst_error", 32'(rx_error), 32'd0);
        rst = 1'b0;
        idle(2);
        drain("mrst");

        // FSM must be back in IDLE and accept a fresh handshake.
        r0 = ready_cnt;
        send_byte(8'h80);
        send_byte(8'hD2);
        send_eop();
        idle(4);
        chk("post_packet", 32'(rx_packet), 32'd4);
        chk("post_ready", 32'(ready_cnt - r0), 32'd1);
        chk("post_error", 32'(rx_error), 32'd0);
        drain("post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
